// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a fixed 26-note table at a set tempo and drives the speaker.
// Optional TEMPO_SEL_EN adds a 2-bit tempo input that scales the beat period.
module melody_sequencer #(
    parameter int BEAT_DIV  = 6250000,
    parameter int GAP_CYC   = 625000,
    parameter int NUM_STEPS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        loop_en,
`ifdef TEMPO_SEL_EN
    input  logic [1:0]  tempo,
`endif
    input  logic [13:0] tones,
    output logic        nota,
    output logic [7:0]  step,
    output logic [3:0]  note_code,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYC > 0) ? 32'(GAP_CYC - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [7:0]  step_q, step_d;
    logic [31:0] beat_q, beat_d;
    logic [2:0]  unit_q, unit_d;
    logic [31:0] gap_q, gap_d;
    logic        nota_q, nota_d;
    logic        done_q, done_d;
    logic [31:0] beat_last;
    logic [2:0]  unit_last;
    logic [15:0] tones_ext;
    logic        sel_tone;
    state_t      adv_state;
    logic [7:0]  adv_step;
    logic        adv_done;

    function automatic logic [3:0] code_of(input logic [7:0] s);
        logic [3:0] c;
        case (s)
            8'd0, 8'd2, 8'd4, 8'd6, 8'd8:              c = 4'd6;
            8'd1, 8'd5, 8'd9, 8'd13:                   c = 4'd2;
            8'd3, 8'd7, 8'd11, 8'd15, 8'd19, 8'd23:    c = 4'd3;
            8'd10, 8'd12, 8'd14, 8'd16:                c = 4'd0;
            8'd17, 8'd21, 8'd25:                       c = 4'd5;
            8'd18, 8'd20, 8'd22, 8'd24:                c = 4'd7;
            default:                                   c = 4'd11;
        endcase
        return c;
    endfunction

`ifdef TEMPO_SEL_EN
    logic [1:0] tempo_q, tempo_d;
    logic [1:0] tempo_eff;

    // Tempo 3 is clamped to 2; the shift only ever uses the latched value.
    always_comb begin
        tempo_eff = (tempo_q == 2'd3) ? 2'd2 : tempo_q;
        beat_last = (32'(BEAT_DIV) << tempo_eff) - 32'd1;
    end
`else
    assign beat_last = 32'(BEAT_DIV) - 32'd1;
`endif

    assign unit_last = (step_q == 8'd25) ? 3'd3 : 3'd0;
    assign note_code = (state_q == IDLE) ? 4'd11 : code_of(step_q);
    assign tones_ext = {2'b00, tones};
    assign sel_tone  = tones_ext[note_code];

    // End-of-step decision: next step, wrap when looping, or finish.
    always_comb begin
        adv_state = PLAY;
        adv_step  = step_q + 8'd1;
        adv_done  = 1'b0;
        if (step_q >= LAST_STEP) begin
            adv_step = 8'd0;
            if (!loop_en) begin
                adv_state = IDLE;
                adv_done  = 1'b1;
            end
        end
    end

    // Next-state and datapath; stop overrides everything, pause freezes.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        beat_d  = beat_q;
        unit_d  = unit_q;
        gap_d   = gap_q;
        nota_d  = 1'b0;
        done_d  = 1'b0;
`ifdef TEMPO_SEL_EN
        tempo_d = tempo_q;
`endif
        if (stop) begin
            state_d = IDLE;
            step_d  = 8'd0;
            beat_d  = 32'd0;
            unit_d  = 3'd0;
            gap_d   = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = PLAY;
                        step_d  = 8'd0;
                        beat_d  = 32'd0;
                        unit_d  = 3'd0;
                        gap_d   = 32'd0;
`ifdef TEMPO_SEL_EN
                        tempo_d = tempo;
`endif
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        nota_d = sel_tone;
                        if (beat_q == beat_last) begin
                            beat_d = 32'd0;
`ifdef TEMPO_SEL_EN
                            tempo_d = tempo;
`endif
                            if (unit_q == unit_last) begin
                                unit_d = 3'd0;
                                if (GAP_CYC == 0) begin
                                    state_d = adv_state;
                                    step_d  = adv_step;
                                    done_d  = adv_done;
                                end else begin
                                    state_d = GAP;
                                    gap_d   = 32'd0;
                                end
                            end else begin
                                unit_d = unit_q + 3'd1;
                            end
                        end else begin
                            beat_d = beat_q + 32'd1;
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gap_q == GAP_LAST) begin
                            gap_d   = 32'd0;
                            state_d = adv_state;
                            step_d  = adv_step;
                            done_d  = adv_done;
                        end else begin
                            gap_d = gap_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = 8'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 8'd0;
            beat_q  <= 32'd0;
            unit_q  <= 3'd0;
            gap_q   <= 32'd0;
            nota_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TEMPO_SEL_EN
            tempo_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            beat_q  <= beat_d;
            unit_q  <= unit_d;
            gap_q   <= gap_d;
            nota_q  <= nota_d;
            done_q  <= done_d;
`ifdef TEMPO_SEL_EN
            tempo_q <= tempo_d;
`endif
        end
    end

    assign nota = nota_q;
    assign step = step_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule
